mem_data_port: RTL and testbench

MEM-stage data-memory port. It consumes the MEM-stage access request (address, byte enable, store data, funct3) and runs one request/response transaction on the data-cache interface per instruction. It stalls the pipeline until the response arrives, shifts store data into byte lanes, and returns aligned, sign/zero-extended load data to the MEM/WB register.

---
 rtl/mem_data_port.sv | 149 ++++++++++++++
 tb/tb_mem_data_port.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_data_port.sv
// MEM-stage data-memory port: issues one request/response transaction on the
// data-cache interface per instruction, stalling the pipeline until the response arrives.
module mem_data_port #(
  parameter bit ALIGN_CHECK = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_read,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_wmask,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  input  logic        pipe_advance,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [31:0] dmem_address,
  output logic [3:0]  dmem_byte_enable,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_resp,
  input  logic [31:0] dmem_rdata,
  output logic        stall_out,
  output logic [31:0] load_data,
  output logic        misalign
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        read_q, read_d;
  logic        write_q, write_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  off_q, off_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] load_q, load_d;

  logic        req_any;
  logic        aligned;
  logic        mis;
  logic        req_ok;
  logic [31:0] st_data;
  logic [31:0] rd_shift;
  logic [31:0] ld_ext;

  // Request decode: alignment by access width and store-lane placement
  always_comb begin
    req_any = req_read | req_write;
    case (req_funct3[1:0])
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = (req_addr[1:0] != 2'b11);
      default: aligned = (req_addr[1:0] == 2'b00);
    endcase
    mis    = ALIGN_CHECK && req_any && !aligned;
    req_ok = req_any && !mis;
    case (req_funct3[1:0])
      2'b00:   st_data = {24'b0, req_wdata[7:0]} << {req_addr[1:0], 3'b000};
      2'b01:   st_data = {16'b0, req_wdata[15:0]} << {req_addr[1:0], 3'b000};
      default: st_data = req_wdata;
    endcase
  end

  // Response path uses the offset and width captured at issue, not the live request
  always_comb begin
    rd_shift = dmem_rdata >> {off_q, 3'b000};
    case (f3_q)
      3'b000:  ld_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b100:  ld_ext = {24'b0, rd_shift[7:0]};
      3'b001:  ld_ext = {{16{rd_shift[15]}}, rd_shift[15:0]};
      3'b101:  ld_ext = {16'b0, rd_shift[15:0]};
      default: ld_ext = rd_shift;
    endcase
  end

  always_comb begin
    state_d = state_q;
    read_d  = read_q;
    write_d = write_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    off_d   = off_q;
    f3_d    = f3_q;
    load_d  = load_q;
    case (state_q)
      IDLE: begin
        if (req_ok) begin
          write_d = req_write;
          read_d  = req_read & ~req_write;
          addr_d  = {req_addr[31:2], 2'b00};
          be_d    = req_wmask;
          wdata_d = st_data;
          off_d   = req_addr[1:0];
          f3_d    = req_funct3;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (dmem_resp) begin
          read_d  = 1'b0;
          write_d = 1'b0;
          if (read_q) load_d = ld_ext;
          state_d = DONE;
        end
      end
      DONE: begin
        if (pipe_advance) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      off_q   <= '0;
      f3_q    <= '0;
      load_q  <= '0;
    end else begin
      state_q <= state_d;
      read_q  <= read_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      off_q   <= off_d;
      f3_q    <= f3_d;
      load_q  <= load_d;
    end
  end

  assign dmem_read        = read_q;
  assign dmem_write       = write_q;
  assign dmem_address     = addr_q;
  assign dmem_byte_enable = be_q;
  assign dmem_wdata       = wdata_q;
  assign load_data        = load_q;
  assign misalign         = (state_q == IDLE) && mis;
  assign stall_out        = ((state_q == IDLE) && req_ok) || (state_q == BUSY);

endmodule

// File: tb/tb_mem_data_port.sv
// Scoreboard bench for mem_data_port: directed scenarios plus randomized loads/stores
// against a width/offset-based reference model; a negedge monitor checks issues and completions.
module tb_mem_data_port;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_read = 1'b0, req_write = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [3:0]  req_wmask = '0;
  logic [2:0]  req_funct3 = '0;
  logic        pipe_advance = 1'b0;
  logic        dmem_resp = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic        dmem_read, dmem_write, stall_out, misalign;
  logic [31:0] dmem_address, dmem_wdata, load_data;
  logic [3:0]  dmem_byte_enable;

  logic        n_req_read = 1'b0, n_resp = 1'b0, n_adv = 1'b0;
  logic [31:0] n_addr = '0, n_rdata = '0;
  logic        n_dmem_read, n_dmem_write, n_stall, n_misalign;
  logic [31:0] n_dmem_address, n_dmem_wdata, n_load_data;
  logic [3:0]  n_dmem_be;

  always #5 clk = ~clk;

  mem_data_port #(.ALIGN_CHECK(1'b1)) dut (
    .clk(clk), .rst(rst), .req_read(req_read), .req_write(req_write), .req_addr(req_addr),
    .req_wmask(req_wmask), .req_wdata(req_wdata), .req_funct3(req_funct3),
    .pipe_advance(pipe_advance), .dmem_read(dmem_read), .dmem_write(dmem_write),
    .dmem_address(dmem_address), .dmem_byte_enable(dmem_byte_enable), .dmem_wdata(dmem_wdata),
    .dmem_resp(dmem_resp), .dmem_rdata(dmem_rdata), .stall_out(stall_out),
    .load_data(load_data), .misalign(misalign));

  mem_data_port #(.ALIGN_CHECK(1'b0)) dut_nochk (
    .clk(clk), .rst(rst), .req_read(n_req_read), .req_write(1'b0), .req_addr(n_addr),
    .req_wmask(4'hF), .req_wdata(32'h0), .req_funct3(3'b010),
    .pipe_advance(n_adv), .dmem_read(n_dmem_read), .dmem_write(n_dmem_write),
    .dmem_address(n_dmem_address), .dmem_byte_enable(n_dmem_be), .dmem_wdata(n_dmem_wdata),
    .dmem_resp(n_resp), .dmem_rdata(n_rdata), .stall_out(n_stall),
    .load_data(n_load_data), .misalign(n_misalign));

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
  } issue_t;

  issue_t      issue_q[$];
  logic [31:0] done_q[$];
  logic [31:0] model_ld = '0;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic int unsigned width_of(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic bit is_aligned(input logic [2:0] f3, input logic [31:0] addr);
    int unsigned w = width_of(f3);
    return ((addr % w) == 0) || (w == 2 && addr[1:0] == 2'b01);
  endfunction

  function automatic logic [31:0] exp_store(input logic [2:0] f3, input logic [1:0] off,
                                            input logic [31:0] wd);
    int unsigned w = width_of(f3);
    longint unsigned v;
    if (w == 4) return wd;
    v = (longint'(wd) & ((64'd1 << (8 * w)) - 1)) << (8 * int'(off));
    return v[31:0];
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] rd);
    longint unsigned v = longint'(rd) >> (8 * int'(off));
    case (f3)
      3'b000: begin v = v % 256;   if (v >= 128)   v = v + 64'hFFFF_FF00; end
      3'b100: v = v % 256;
      3'b001: begin v = v % 65536; if (v >= 32768) v = v + 64'hFFFF_0000; end
      3'b101: v = v % 65536;
      default: ;
    endcase
    return v[31:0];
  endfunction

  // Monitor: a rising request must match the oldest expected issue; a falling one
  // (outside reset) marks completion and load_data must match the oldest expectation.
  logic prev_act = 1'b0, prev_rst = 1'b1;
  always @(negedge clk) begin
    logic   cur;
    issue_t e;
    cur = dmem_read | dmem_write;
    if (cur && !prev_act) begin
      if (issue_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_issue actual=%h required=none", dmem_address);
      end else begin
        e = issue_q.pop_front();
        chk("issue_read", {31'b0, dmem_read}, {31'b0, e.rd});
        chk("issue_write", {31'b0, dmem_write}, {31'b0, e.wr});
        chk("issue_addr", dmem_address, e.addr);
        chk("issue_be", {28'b0, dmem_byte_enable}, {28'b0, e.be});
        if (e.wr) chk("issue_wdata", dmem_wdata, e.wd);
      end
    end
    if (!cur && prev_act && !prev_rst) begin
      if (done_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done actual=%h required=none", load_data);
      end else begin
        chk("done_load_data", load_data, done_q.pop_front());
        chk("done_stall", {31'b0, stall_out}, 32'd0);
      end
    end
    prev_act = cur;
    prev_rst = rst;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle(input logic stray);
    req_read = 1'b0; req_write = 1'b0; dmem_resp = stray; pipe_advance = 1'b1;
    @(negedge clk);
    chk("idle_stall", {31'b0, stall_out}, 32'd0);
    chk("idle_load_data", load_data, model_ld);
    step();
    dmem_resp = 1'b0;
  endtask

  task automatic run_txn(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [3:0] wm, input logic [31:0] wd, input logic [2:0] f3,
                         input int resp_dly, input logic [31:0] rdata, input int adv_dly);
    issue_t e;
    req_read = rd; req_write = wr; req_addr = addr; req_wmask = wm;
    req_wdata = wd; req_funct3 = f3; pipe_advance = 1'b0;
    if (!is_aligned(f3, addr)) begin
      @(negedge clk);
      chk("mis_flag", {31'b0, misalign}, 32'd1);
      chk("mis_stall", {31'b0, stall_out}, 32'd0);
      step();
      @(negedge clk);
      chk("mis_no_issue", {31'b0, dmem_read | dmem_write}, 32'd0);
      chk("mis_load_data", load_data, model_ld);
      step();
      return;
    end
    e.wr = wr; e.rd = rd & ~wr; e.addr = {addr[31:2], 2'b00}; e.be = wm;
    e.wd = exp_store(f3, addr[1:0], wd);
    issue_q.push_back(e);
    if (e.rd) model_ld = exp_load(f3, addr[1:0], rdata);
    done_q.push_back(model_ld);
    @(negedge clk);
    chk("req_stall", {31'b0, stall_out}, 32'd1);
    chk("req_misalign", {31'b0, misalign}, 32'd0);
    for (int c = 1; c <= resp_dly; c++) begin
      step();
      if (c == resp_dly) begin dmem_resp = 1'b1; dmem_rdata = rdata; end
      @(negedge clk);
      chk("busy_stall", {31'b0, stall_out}, 32'd1);
      chk("busy_active", {31'b0, dmem_read | dmem_write}, 32'd1);
    end
    step();
    dmem_resp = 1'b0; dmem_rdata = $urandom;
    @(negedge clk);
    chk("done_stall_first", {31'b0, stall_out}, 32'd0);
    for (int i = 0; i < adv_dly; i++) begin
      step();
      dmem_resp = (i == 0);
      @(negedge clk);
      chk("hold_stall", {31'b0, stall_out}, 32'd0);
      chk("hold_no_reissue", {31'b0, dmem_read | dmem_write}, 32'd0);
      chk("hold_load_data", load_data, model_ld);
    end
    step();
    dmem_resp = 1'b0; pipe_advance = 1'b1;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    step(); step();
    @(negedge clk);
    chk("rst_read", {31'b0, dmem_read}, 32'd0);
    chk("rst_write", {31'b0, dmem_write}, 32'd0);
    chk("rst_addr", dmem_address, 32'd0);
    chk("rst_be", {28'b0, dmem_byte_enable}, 32'd0);
    chk("rst_wdata", dmem_wdata, 32'd0);
    chk("rst_load_data", load_data, 32'd0);
    chk("rst_stall", {31'b0, stall_out}, 32'd0);
    step();
    rst = 1'b0;

    run_txn(1, 0, 32'h100, 4'hF, 32'h0, 3'b010, 4, 32'hDEADBEEF, 0);
    chk("lw_result", load_data, 32'hDEADBEEF);
    run_txn(1, 0, 32'h103, 4'h8, 32'h0, 3'b000, 1, 32'h80FF1234, 0);
    chk("lb_result", load_data, 32'hFFFFFF80);
    run_txn(1, 0, 32'h103, 4'h8, 32'h0, 3'b100, 2, 32'h80FF1234, 0);
    chk("lbu_result", load_data, 32'h00000080);
    run_txn(1, 0, 32'h102, 4'hC, 32'h0, 3'b001, 1, 32'h80FF1234, 0);
    chk("lh_result", load_data, 32'hFFFF80FF);
    run_txn(0, 1, 32'h202, 4'hC, 32'h0000ABCD, 3'b001, 3, 32'h12345678, 0);
    chk("sh_keeps_load", load_data, 32'hFFFF80FF);
    run_txn(1, 0, 32'h101, 4'hF, 32'h0, 3'b010, 1, 32'h0, 0);
    run_txn(1, 0, 32'h10C, 4'hF, 32'h0, 3'b010, 2, 32'h13579BDF, 3);
    run_txn(1, 1, 32'h111, 4'h2, 32'h000000A5, 3'b000, 1, 32'hFFFFFFFF, 0);

    // Reset while BUSY, then a stale response two cycles after reset asserts
    req_read = 1'b1; req_write = 1'b0; req_addr = 32'h400; req_funct3 = 3'b010;
    req_wmask = 4'hF; pipe_advance = 1'b0;
    issue_q.push_back('{rd: 1'b1, wr: 1'b0, addr: 32'h400, be: 4'hF, wd: 32'h0});
    step();
    rst = 1'b1;
    step();
    rst = 1'b0; req_read = 1'b0; model_ld = '0;
    @(negedge clk);
    chk("rst_busy_read", {31'b0, dmem_read}, 32'd0);
    chk("rst_busy_load", load_data, 32'd0);
    step();
    dmem_resp = 1'b1; dmem_rdata = 32'hBAD0BAD0;
    @(negedge clk);
    chk("stale_resp_stall", {31'b0, stall_out}, 32'd0);
    chk("stale_resp_load", load_data, 32'd0);
    step();
    dmem_resp = 1'b0;
    run_txn(0, 1, 32'h300, 4'hF, 32'hCAFEF00D, 3'b010, 2, 32'h0, 1);

    for (int n = 0; n < 40; n++) begin
      logic [2:0] f3;
      int unsigned k = $urandom_range(0, 9);
      logic rd = (k <= 4) || (k == 9);
      logic wr = (k >= 5);
      if (wr) f3 = 3'($urandom_range(0, 2));
      else begin
        f3 = 3'($urandom_range(0, 4));
        if (f3 == 3'd3) f3 = 3'd5;
      end
      run_txn(rd, wr, $urandom, 4'($urandom), $urandom, f3,
              $urandom_range(1, 4), $urandom, $urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) idle_cycle(1'b1);
    end
    idle_cycle(1'b0);

    // Same misaligned word load without alignment checking is issued word-truncated
    n_req_read = 1'b1; n_addr = 32'h101; n_adv = 1'b0;
    @(negedge clk);
    chk("nochk_stall", {31'b0, n_stall}, 32'd1);
    chk("nochk_misalign", {31'b0, n_misalign}, 32'd0);
    step();
    @(negedge clk);
    chk("nochk_read", {31'b0, n_dmem_read}, 32'd1);
    chk("nochk_addr", n_dmem_address, 32'h100);
    step();
    n_resp = 1'b1; n_rdata = 32'hDEADBEEF;
    step();
    n_resp = 1'b0; n_req_read = 1'b0; n_adv = 1'b1;
    @(negedge clk);
    chk("nochk_load", n_load_data, exp_load(3'b010, 2'b01, 32'hDEADBEEF));
    step();

    chk("issue_q_drained", 32'(issue_q.size()), 32'd0);
    chk("done_q_drained", 32'(done_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
